// File: rtl/channel_pkg.sv
// -----------------------------------------------------------------------------
// channel_pkg
//
// Shared definitions for the channel scheduler: source count, select width,
// hold-counter width, the scheduler state encoding, the destination encodings
// driven onto the demux select, and a one-hot helper.
//
// No ports (package).
// -----------------------------------------------------------------------------
package channel_pkg;

    localparam int NUM_SRC = 4;   // switch groups competing for the channel
    localparam int SEL_W   = 2;   // width of mux / demux selects
    localparam int HOLD_W  = 8;   // width of the enable hold counter

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Demux outputs, in select order.
    typedef enum logic [SEL_W-1:0] {
        DST_LIBRARY  = 2'd0,
        DST_FIREDEPO = 2'd1,
        DST_SCHOOL   = 2'd2,
        DST_RIBSHACK = 2'd3
    } dst_t;

    // One-hot source vector for a source index.
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SEL_W-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin pick among pending requests. The winner is
// the lowest index >= i_ptr that is requesting, wrapping modulo NUM_SRC.
//
// Ports:
//   i_req     in  NUM_SRC  pending requests, bit i = source i
//   i_ptr     in  SEL_W    first index to consider this round
//   o_winner  out SEL_W    index of the chosen source (0 when none)
//   o_valid   out 1        at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter
    import channel_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic [SEL_W-1:0]   o_winner,
    output logic               o_valid
);

    logic [SEL_W-1:0] w_idx;

    // NOTE: every signal written here is given a default before the loop, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        o_valid  = |i_req;
        o_winner = '0;
        w_idx    = '0;
        // Scan from the farthest offset back to the pointer so the closest
        // requester (smallest rotated offset) is the last to assign and wins.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_idx = i_ptr + SEL_W'(k);   // 2-bit add wraps modulo NUM_SRC
            if (i_req[w_idx]) begin
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/channel_scheduler.sv
// -----------------------------------------------------------------------------
// channel_scheduler
//
// Sequencing controller for the shared 4-bit send/receive channel. Four
// sources compete for the single mux -> demux path. An idle request is
// arbitrated round-robin, the winner's destination is latched, and the
// selects are presented for one SETUP cycle before the shared enable is held
// for HOLD_CYCLES cycles. A RELEASE cycle with the enable low then acks the
// winner, so select changes never happen while the enable is high.
//
// Parameters:
//   HOLD_CYCLES  cycles chan_en stays high per transfer (1..255)
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  synchronous, active-high reset
//   req      in   4  per-source transfer request
//   req_dst  in   8  destination per source, bits [2i+1:2i] for source i
//   src_sel  out  2  mux select (granted source)
//   dst_sel  out  2  demux select (latched destination of granted source)
//   chan_en  out  1  shared mux/demux enable
//   grant    out  4  one-hot owner, SETUP through RELEASE
//   ack      out  4  one-cycle pulse to the served source in RELEASE
//   busy     out  1  high whenever not IDLE
// -----------------------------------------------------------------------------
module channel_scheduler
    import channel_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*SEL_W-1:0]  req_dst,
    output logic [SEL_W-1:0]          src_sel,
    output logic [SEL_W-1:0]          dst_sel,
    output logic                      chan_en,
    output logic [NUM_SRC-1:0]        grant,
    output logic [NUM_SRC-1:0]        ack,
    output logic                      busy
);

    // Value loaded in SETUP; XFER then runs while the counter walks down to 0,
    // which gives exactly HOLD_CYCLES enable cycles.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    state_t               r_state;
    logic [SEL_W-1:0]     r_ptr;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [SEL_W-1:0]     r_src_sel;
    dst_t                 r_dst_sel;
    logic [NUM_SRC-1:0]   r_grant;
    logic                 r_chan_en;
    logic [NUM_SRC-1:0]   r_ack;
    logic                 r_busy;

    // ---------------------------------------------------------------------
    // Next-state values
    // ---------------------------------------------------------------------
    state_t               w_next_state;
    logic [SEL_W-1:0]     w_next_ptr;
    logic [HOLD_W-1:0]    w_next_hold_cnt;
    logic [SEL_W-1:0]     w_next_src_sel;
    dst_t                 w_next_dst_sel;
    logic [NUM_SRC-1:0]   w_next_grant;
    logic                 w_next_chan_en;
    logic [NUM_SRC-1:0]   w_next_ack;
    logic                 w_next_busy;

    // Arbiter result
    logic [SEL_W-1:0]     w_winner;
    logic                 w_arb_valid;

    rr_arbiter u_rr_arbiter (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_arb_valid)
    );

    // ---------------------------------------------------------------------
    // Next-state and next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state    = r_state;
        w_next_ptr      = r_ptr;
        w_next_hold_cnt = r_hold_cnt;
        w_next_src_sel  = r_src_sel;
        w_next_dst_sel  = r_dst_sel;
        w_next_grant    = r_grant;

        unique case (r_state)
            IDLE: begin
                // req / req_dst are only looked at here; the selects keep
                // their last values until a new winner is latched.
                if (w_arb_valid) begin
                    w_next_src_sel = w_winner;
                    w_next_dst_sel = dst_t'(req_dst[{w_winner, 1'b0} +: SEL_W]);
                    w_next_grant   = src_onehot(w_winner);
                    w_next_state   = SETUP;
                end
            end

            SETUP: begin
                w_next_hold_cnt = HOLD_LOAD;
                w_next_state    = XFER;
            end

            XFER: begin
                // Counter saturates at 0 so it can never wrap; the last
                // enable cycle is the one that sees 0.
                if (r_hold_cnt != '0) begin
                    w_next_hold_cnt = r_hold_cnt - 1'b1;
                end else begin
                    w_next_state = RELEASE;
                end
            end

            RELEASE: begin
                w_next_ptr   = r_src_sel + 1'b1;   // wraps 3 -> 0
                w_next_grant = '0;
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so each
        // one changes exactly on the edge that enters the corresponding state.
        w_next_chan_en = (w_next_state == XFER);
        w_next_ack     = (w_next_state == RELEASE) ? w_next_grant : '0;
        w_next_busy    = (w_next_state != IDLE);
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: every register is reset here, including the pointer and hold
        // counter; an in-flight transfer is dropped with no ack.
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_src_sel  <= '0;
            r_dst_sel  <= DST_LIBRARY;
            r_grant    <= '0;
            r_chan_en  <= 1'b0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ptr      <= w_next_ptr;
            r_hold_cnt <= w_next_hold_cnt;
            r_src_sel  <= w_next_src_sel;
            r_dst_sel  <= w_next_dst_sel;
            r_grant    <= w_next_grant;
            r_chan_en  <= w_next_chan_en;
            r_ack      <= w_next_ack;
            r_busy     <= w_next_busy;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign src_sel = r_src_sel;
    assign dst_sel = r_dst_sel;
    assign chan_en = r_chan_en;
    assign grant   = r_grant;
    assign ack     = r_ack;
    assign busy    = r_busy;

endmodule

// File: tb/tb_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_channel_scheduler
//
// Scoreboard bench for channel_scheduler. Stimulus pushes the expected
// transfer (source, destination, grant spacing) into a queue; a monitor on the
// falling edge follows each transfer from its SETUP cycle to its ack and
// compares timing, selects and ack against the queued item. A second instance
// with HOLD_CYCLES=1 is checked with direct vectors.
// -----------------------------------------------------------------------------
module tb_channel_scheduler;

    localparam int HOLD = 4;

    typedef struct {
        logic [1:0] src;
        logic [1:0] dst;
        int         gap;    // expected cycles since previous grant, 0 = don't care
    } exp_t;

    logic       clk;
    logic       rst;

    // HOLD_CYCLES=4 instance
    logic [3:0] req4;
    logic [7:0] req4_dst;
    logic [1:0] src_sel4, dst_sel4;
    logic       chan_en4, busy4;
    logic [3:0] grant4, ack4;

    // HOLD_CYCLES=1 instance
    logic [3:0] req1;
    logic [7:0] req1_dst;
    logic [1:0] src_sel1, dst_sel1;
    logic       chan_en1, busy1;
    logic [3:0] grant1, ack1;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    channel_scheduler #(.HOLD_CYCLES(HOLD)) dut4 (
        .clk     (clk),
        .reset   (rst),
        .req     (req4),
        .req_dst (req4_dst),
        .src_sel (src_sel4),
        .dst_sel (dst_sel4),
        .chan_en (chan_en4),
        .grant   (grant4),
        .ack     (ack4),
        .busy    (busy4)
    );

    channel_scheduler #(.HOLD_CYCLES(1)) dut1 (
        .clk     (clk),
        .reset   (rst),
        .req     (req1),
        .req_dst (req1_dst),
        .src_sel (src_sel1),
        .dst_sel (dst_sel1),
        .chan_en (chan_en1),
        .grant   (grant1),
        .ack     (ack1),
        .busy    (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic push_exp(input logic [1:0] src, input logic [1:0] dst, input int gap);
        exp_t e;
        e.src = src;
        e.dst = dst;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Wait until every queued transfer has been acked and the block is idle.
    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy4 && req4 == 4'b0) return;
        end
        fail("wait_done_timeout");
    endtask

    task automatic wait_chan_en();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (chan_en4) return;
        end
        fail("wait_chan_en_timeout");
    endtask

    // Requesters release their request once they see their ack.
    always @(negedge clk) begin
        req4 = req4 & ~ack4;
    end

    // ---------------------------------------------------------------------
    // Monitor / scoreboard for the HOLD_CYCLES=4 instance
    // ---------------------------------------------------------------------
    int   cyc        = 0;
    int   t_setup    = 0;
    int   last_grant = 0;
    int   en_cnt     = 0;
    bit   active     = 1'b0;
    bit   stable     = 1'b1;
    bit   idle_next  = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (active && exp_q.size() > 0) void'(exp_q.pop_front());
            active    = 1'b0;
            idle_next = 1'b0;
        end else begin
            if (idle_next) begin
                check("idle_after_ack", {27'd0, busy4, grant4}, 32'd0);
                idle_next = 1'b0;
            end
            if (!active && grant4 != 4'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", {28'd0, grant4}, 32'd0);
                end else begin
                    cur     = exp_q[0];
                    active  = 1'b1;
                    t_setup = cyc;
                    en_cnt  = 0;
                    stable  = 1'b1;
                    check("setup_src_sel", {30'd0, src_sel4}, {30'd0, cur.src});
                    check("setup_dst_sel", {30'd0, dst_sel4}, {30'd0, cur.dst});
                    check("setup_chan_en_low", {31'd0, chan_en4}, 32'd0);
                    if (cur.gap != 0) check("grant_gap", cyc - last_grant, cur.gap);
                    last_grant = cyc;
                end
            end
            if (active) begin
                if (chan_en4) en_cnt++;
                if (src_sel4 != cur.src || dst_sel4 != cur.dst ||
                    grant4 != (4'b0001 << cur.src)) stable = 1'b0;
            end
            if (ack4 != 4'b0) begin
                if (!active) begin
                    check("unexpected_ack", {28'd0, ack4}, 32'd0);
                end else begin
                    check("ack_onehot", {28'd0, ack4}, 32'd1 << cur.src);
                    check("chan_en_cycles", en_cnt, HOLD);
                    check("ack_latency", cyc - t_setup, HOLD + 1);
                    check("release_chan_en_low", {31'd0, chan_en4}, 32'd0);
                    check("selects_stable", {31'd0, stable}, 32'd1);
                    void'(exp_q.pop_front());
                    active    = 1'b0;
                    idle_next = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    logic [7:0] en_mask;
    int         ack_at;
    logic [3:0] ack_val;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req4     = 4'b0;
        req4_dst = 8'h00;
        req1     = 4'b0;
        req1_dst = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state held with no requests.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle_outputs",
                  {20'd0, src_sel4, dst_sel4, chan_en4, grant4, ack4, busy4}, 32'd0);
        end

        // All four request together: served 0,1,2,3, seven cycles apart.
        req4_dst = 8'b00_01_10_11;
        push_exp(2'd0, 2'd3, 0);
        push_exp(2'd1, 2'd2, 7);
        push_exp(2'd2, 2'd1, 7);
        push_exp(2'd3, 2'd0, 7);
        req4 = 4'b1111;
        wait_done();                          // ptr back to 0

        // Single request, source 2 to Rib shack.
        req4_dst = 8'b00_11_00_00;
        push_exp(2'd2, 2'd3, 0);
        req4 = 4'b0100;
        wait_done();                          // ptr = 3

        // Source 1 alone moves the pointer to 2.
        req4_dst = 8'b00_00_01_00;
        push_exp(2'd1, 2'd1, 0);
        req4 = 4'b0010;
        wait_done();                          // ptr = 2

        // ptr=2 with sources 0 and 1 pending: wrap to 0 first, then 1.
        req4_dst = 8'b00_00_10_01;
        push_exp(2'd0, 2'd1, 0);
        push_exp(2'd1, 2'd2, 7);
        req4 = 4'b0011;
        wait_done();                          // ptr = 2

        // Destination change and request drop mid-XFER are ignored.
        req4_dst = 8'b10_00_00_00;
        push_exp(2'd3, 2'd2, 0);
        req4 = 4'b1000;
        wait_chan_en();
        @(negedge clk);
        req4_dst = 8'b11_11_11_11;
        req4     = 4'b0000;
        wait_done();                          // ptr = 0

        // Source 0 transfer leaves ptr = 1.
        req4_dst = 8'b00_00_00_01;
        push_exp(2'd0, 2'd1, 0);
        req4 = 4'b0001;
        wait_done();

        // Reset on the second XFER cycle drops the transfer with no ack.
        req4_dst = 8'b00_10_00_00;
        push_exp(2'd2, 2'd2, 0);
        req4 = 4'b0100;
        wait_chan_en();
        @(negedge clk);
        rst  = 1'b1;
        req4 = 4'b0000;
        @(negedge clk);
        check("abort_chan_en", {31'd0, chan_en4}, 32'd0);
        check("abort_grant", {28'd0, grant4}, 32'd0);
        check("abort_ack", {28'd0, ack4}, 32'd0);
        check("abort_busy_selects", {27'd0, busy4, src_sel4, dst_sel4}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", {28'd0, ack4}, 32'd0);
        end

        // After reset ptr=0: sources 0 and 3 pending -> 0 first, then 3.
        req4_dst = 8'b11_00_00_10;
        push_exp(2'd0, 2'd2, 0);
        push_exp(2'd3, 2'd3, 7);
        req4 = 4'b1001;
        wait_done();

        // HOLD_CYCLES=1: SETUP, one enable cycle, RELEASE with ack, IDLE.
        @(negedge clk);
        req1_dst = 8'b00_11_00_00;
        req1     = 4'b0100;
        en_mask  = 8'd0;
        ack_at   = -1;
        ack_val  = 4'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (chan_en1) en_mask[k] = 1'b1;
            if (k == 1) begin
                check("h1_setup_src_sel", {30'd0, src_sel1}, 32'd2);
                check("h1_setup_dst_sel", {30'd0, dst_sel1}, 32'd3);
                check("h1_setup_grant", {28'd0, grant1}, 32'b0100);
            end
            if (ack1 != 4'b0) begin
                ack_at  = k;
                ack_val = ack1;
                req1    = 4'b0;
            end
        end
        check("h1_chan_en_cycles", {24'd0, en_mask}, 32'b0000_0100);
        check("h1_ack_cycle", ack_at, 3);
        check("h1_ack_value", {28'd0, ack_val}, 32'b0100);
        check("h1_idle_busy", {31'd0, busy1}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
